// File: rtl/calc_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the calculator ALU.
package calc_alu_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/calc_alu_if.sv
// Command/result bundle between the UART command parser, the ALU and the result formatter.
interface calc_alu_if #(
  parameter int WIDTH = 16
);

  logic [3:0]         start_alu;
  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
  logic               busy;
  logic               alu_done;
  logic               alu_err;
  logic               cmd_drop;
  logic [2*WIDTH-1:0] calc_res;

  modport master (
    output start_alu, src1, src2,
    input  busy, alu_done, alu_err, cmd_drop, calc_res
  );

  modport slave (
    input  start_alu, src1, src2,
    output busy, alu_done, alu_err, cmd_drop, calc_res
  );

endinterface

// File: rtl/calc_alu_seq.sv
// Iterative engine: shift-add multiply, and restoring divide when CALC_ALU_DIV_EN is defined.
// One bit per cycle for WIDTH cycles after start_i; res_o is the value the current step produces.
module calc_alu_seq
  import calc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
`ifdef CALC_ALU_DIV_EN
  input  logic               div_i,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               active_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opd_q;
  logic [WIDTH:0]     mul_sum;
`ifdef CALC_ALU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   trial;
  logic               ge;
`endif

  // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef CALC_ALU_DIV_EN
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial   = shifted[WIDTH-1:0] - opd_q;
    ge      = (shifted >= {1'b0, opd_q});
    if (div_q) begin
      acc_d = {(ge ? trial : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end
`endif
  end

  assign last_o = active_q && (cnt_q == CW'(WIDTH - 1));
  assign res_o  = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
`ifdef CALC_ALU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
`ifdef CALC_ALU_DIV_EN
      div_q    <= div_i;
      acc_q    <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
      opd_q    <= div_i ? b_i : a_i;
`else
      acc_q    <= {{WIDTH{1'b0}}, b_i};
      opd_q    <= a_i;
`endif
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (last_o) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_alu.sv
// Calculator ALU: edge-detected command intake, IDLE/EXEC/DONE FSM and held result registers.
// DIV/MOD are built only when CALC_ALU_DIV_EN is defined; otherwise opcodes 4/5 report an error.
module calc_alu
  import calc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  calc_alu_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      prev_op_q;
  logic [W2-1:0]   res_q;
  logic [W2-1:0]   res_d;
  logic            err_q;
  logic            err_d;
  logic            new_cmd;
  logic            cmd_drop;
  logic            seq_start;
  logic            seq_last;
  logic [W2-1:0]   seq_res;
  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
`ifdef CALC_ALU_DIV_EN
  logic            is_mod_q;
  logic            is_mod_d;
  logic            seq_div;
`endif

  // A command is a change to a non-zero code; holding a code never retriggers.
  assign new_cmd = (bus.start_alu != OP_NONE) && (bus.start_alu != prev_op_q);
  assign sum     = {1'b0, bus.src1} + {1'b0, bus.src2};
  assign diff    = {1'b0, bus.src1} - {1'b0, bus.src2};

  calc_alu_seq #(
    .WIDTH (WIDTH)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (seq_start),
`ifdef CALC_ALU_DIV_EN
    .div_i   (seq_div),
`endif
    .a_i     (bus.src1),
    .b_i     (bus.src2),
    .last_o  (seq_last),
    .res_o   (seq_res)
  );

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    err_d     = err_q;
    seq_start = 1'b0;
    cmd_drop  = 1'b0;
`ifdef CALC_ALU_DIV_EN
    is_mod_d  = is_mod_q;
    seq_div   = (bus.start_alu == OP_DIV) || (bus.start_alu == OP_MOD);
`endif
    case (state_q)
      IDLE: begin
        if (new_cmd) begin
          state_d = DONE;
          case (bus.start_alu)
            OP_ADD: begin
              res_d = {{(WIDTH-1){1'b0}}, sum};
              err_d = 1'b0;
            end
            OP_SUB: begin
              res_d = {{(WIDTH-1){diff[WIDTH]}}, diff};
              err_d = 1'b0;
            end
            OP_MUL: begin
              seq_start = 1'b1;
              state_d   = EXEC;
            end
`ifdef CALC_ALU_DIV_EN
            OP_DIV, OP_MOD: begin
              if (bus.src2 == '0) begin
                err_d = 1'b1;
                res_d = (bus.start_alu == OP_MOD) ? {{WIDTH{1'b0}}, bus.src1}
                                                  : {bus.src1, {WIDTH{1'b1}}};
              end else begin
                seq_start = 1'b1;
                is_mod_d  = (bus.start_alu == OP_MOD);
                state_d   = EXEC;
              end
            end
`endif
            default: begin
              res_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        cmd_drop = new_cmd;
        if (seq_last) begin
          state_d = DONE;
          err_d   = 1'b0;
          res_d   = seq_res;
`ifdef CALC_ALU_DIV_EN
          if (is_mod_q) begin
            res_d = {{WIDTH{1'b0}}, seq_res[W2-1:WIDTH]};
          end
`endif
        end
      end
      DONE: begin
        cmd_drop = new_cmd;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      cmd_drop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_op_q <= OP_NONE;
      res_q     <= '0;
      err_q     <= 1'b0;
`ifdef CALC_ALU_DIV_EN
      is_mod_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      prev_op_q <= bus.start_alu;
      res_q     <= res_d;
      err_q     <= err_d;
`ifdef CALC_ALU_DIV_EN
      is_mod_q  <= is_mod_d;
`endif
    end
  end

  assign bus.busy     = (state_q == EXEC);
  assign bus.alu_done = (state_q == DONE);
  assign bus.alu_err  = err_q;
  assign bus.calc_res = res_q;
  assign bus.cmd_drop = cmd_drop;

endmodule

// File: doc/calc_alu.md
# calc_alu

Parametrised arithmetic engine for the UART calculator, the next generation of the single-cycle adder. Takes two WIDTH-bit operands and a 4-bit operation code, executes add/sub in one cycle and multiply/divide/modulo iteratively (one bit per cycle), and returns a 2·WIDTH result with a done pulse. Sits between the UART command parser (operand/opcode source) and the result formatter (consumer of `calc_res`).

## Interface
- `WIDTH`, 16, operand width in bits (≥4); result is 2·WIDTH.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_alu` in 4: operation code; 0 = no command.
- `src1` in WIDTH: operand A (unsigned).
- `src2` in WIDTH: operand B (unsigned).
- `busy` out 1: high while an iterative op is executing.
- `alu_done` out 1: one-cycle pulse, `calc_res`/`alu_err` valid.
- `alu_err` out 1: error flag for the completed op, held with `calc_res`.
- `cmd_drop` out 1: one-cycle pulse, a command arrived while busy and was discarded.
- `calc_res` out 2·WIDTH: result, held until the next `alu_done`.

## Operation
- Opcodes: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD; 0 idle; 6–15 illegal.
- New command: any cycle where `start_alu` ≠ 0 and differs from its value in the previous cycle (internal `prev_op` register). Holding a code does not retrigger; a direct 1→2→5 change issues three commands.
- Operands sampled in the accepting cycle only; later changes are ignored.
- States: IDLE, EXEC, DONE. IDLE→DONE for ADD/SUB/illegal; IDLE→EXEC for MUL/DIV/MOD; EXEC→DONE after WIDTH iterations; DONE→IDLE unconditionally.
- ADD: `calc_res` = zero-extended WIDTH+1-bit sum.
- SUB: `calc_res` = src1−src2 as WIDTH+1-bit difference, sign-extended to 2·WIDTH (6−2 → 4, 2−6 → all-ones except low bits = …FFFC).
- MUL: unsigned shift-add product, full 2·WIDTH.
- DIV: restoring division; `calc_res` = {remainder, quotient}. MOD: `calc_res` = {WIDTH zeros, remainder}.
- Divide/modulo by zero: no iteration; completes like ADD; quotient = all-ones, remainder = src1, `alu_err`=1.
- Illegal opcode: `calc_res`=0, `alu_err`=1.
- Command while EXEC or DONE: discarded, `cmd_drop` pulses same cycle; `prev_op` still updates, so it is not replayed.

## Timing
- Accept in cycle N. ADD/SUB/illegal/div-by-zero: `alu_done` in N+1. MUL/DIV/MOD: `busy` high N+1..N+WIDTH, `alu_done` in N+WIDTH+1 (N+17 at WIDTH=16).
- `busy` low in the `alu_done` cycle; a new command is accepted from N+2 (single-cycle ops) or N+WIDTH+2 onward.
- Reset values: `busy`=0, `alu_done`=0, `alu_err`=0, `cmd_drop`=0, `calc_res`=0, state IDLE, `prev_op`=0.
- Reset mid-operation: op abandoned, no `alu_done`. Since `prev_op` resets to 0, a non-zero `start_alu` held through reset is accepted in the first cycle after `rst` falls.
- Reset has priority over all other events.

## Configuration
- `CALC_ALU_DIV_EN`: defined → DIV/MOD as above. Undefined → divider datapath not built; opcodes 4/5 treated as illegal (single-cycle, `calc_res`=0, `alu_err`=1). ADD/SUB/MUL unaffected.

## Structure
- Package `calc_alu_pkg`: opcode constants (OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD), state enum (IDLE, EXEC, DONE).
- Sub-module `calc_alu_seq`: iterative shift-add multiplier / restoring divider with iteration counter; top holds command detection, FSM, output registers.

## Test plan
- Reset, then ADD 0x0009+0x0001 → `alu_done` one cycle after accept, `calc_res`=0x0000000A, `alu_err`=0.
- SUB 0x0006−0x0002 → 0x00000004; SUB 0x0002−0x0006 → 0xFFFFFFFC; direct 2→1 code change issues a new command.
- MUL 0xFFFF×0xFFFF → `busy` 16 cycles, `alu_done` at N+17, `calc_res`=0xFFFE0001; holding code 3 afterwards does not retrigger.
- DIV 0x0005/0x0003 → 0x00020001; MOD → 0x00000002; DIV by 0 → 0x0005FFFF with `alu_err`=1 at N+1 (macro defined); macro undefined → DIV gives 0, `alu_err`=1.
- ADD issued mid-MUL → `cmd_drop` pulse, MUL result unaffected, no second `alu_done`.
- `rst` asserted at MUL iteration 8 → all outputs 0, no `alu_done`; code 3 held through reset → accepted the first cycle after release.
